// File: rtl/clmul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : clmul_seq
//  Purpose  : Sequential carry-less (GF(2)) multiplier. Scans one multiplier
//             bit per cycle, MSB first, and emits the unreduced product
//             for the downstream field reducer.
//  Option   : CLMUL_OPERAND_MASK_EN - zero operand bits at positions at or
//             above the latched grade when the operands are captured.
//  Revision : 1.0 - initial release
// ============================================================================
module clmul_seq #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  input  logic [DATA_WIDTH-1:0]         a,
  input  logic [DATA_WIDTH-1:0]         b,
  output logic [2*DATA_WIDTH-1:0]       prod,
  output logic                          busy,
  output logic                          op_finish
);

  localparam int GW = $clog2(DATA_WIDTH) + 1;  // grade width
  localparam int IW = $clog2(DATA_WIDTH);      // bit index width
  localparam int AW = 2*DATA_WIDTH - 1;        // accumulator width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [AW-1:0]           acc_q;
  logic [IW-1:0]           idx_q;
  logic                    err_q;   // invalid-grade request waiting to report
  logic [2*DATA_WIDTH-1:0] prod_q;
  logic                    busy_q;
  logic                    fin_q;

  logic                    w_grade_ok;
  logic [DATA_WIDTH-1:0]   a_d;
  logic [DATA_WIDTH-1:0]   b_d;
  logic [IW-1:0]           idx_d;
  logic [AW-1:0]           acc_d;

  // Request decode: grade range check, operand capture values, start index
  always_comb begin
    w_grade_ok = (polyn_grade >= GW'(2)) && (polyn_grade <= GW'(DATA_WIDTH));
    idx_d      = IW'(polyn_grade - GW'(1));
`ifdef CLMUL_OPERAND_MASK_EN
    a_d = '0;
    b_d = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (GW'(i) < polyn_grade) begin
        a_d[i] = a[i];
        b_d[i] = b[i];
      end
    end
`else
    a_d = a;
    b_d = b;
`endif
  end

  // One MSB-first shift-and-XOR step of the carry-less product
  always_comb begin
    acc_d = (acc_q << 1) ^ (b_q[idx_q] ? {{(AW-DATA_WIDTH){1'b0}}, a_q} : '0);
  end

  // Control FSM with registered busy / op_finish and held product
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      busy_q <= 1'b0;
      fin_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (err_q) begin
            // Invalid grade reports one cycle after acceptance, with no RUN
            err_q   <= 1'b0;
            prod_q  <= '0;
            fin_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (start && w_grade_ok) begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= '0;
            idx_q   <= idx_d;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else if (start) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          idx_q <= idx_q - IW'(1);
          if (idx_q == '0) begin
            prod_q  <= {1'b0, acc_d};
            fin_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prod      = prod_q;
  assign busy      = busy_q;
  assign op_finish = fin_q;

endmodule
`default_nettype wire

// File: tb/tb_clmul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clmul_seq
//  Purpose  : Self-checking bench for clmul_seq (DATA_WIDTH = 4): vector
//             table, hand-written multi-cycle sequences, random operations
//             against a polynomial-product reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clmul_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] polyn_grade;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] prod;
  logic       busy;
  logic       op_finish;

  int checks = 0;
  int fails  = 0;
  logic [7:0] last_prod = 8'h00;

  clmul_seq #(.DATA_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .polyn_grade(polyn_grade),
    .a          (a),
    .b          (b),
    .prod       (prod),
    .busy       (busy),
    .op_finish  (op_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] g;
    logic [3:0] av;
    logic [3:0] bv;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: sum over set multiplier bits of a * x^i in GF(2)
  function automatic logic [7:0] ref_clmul(input logic [2:0] g, input logic [3:0] av,
                                           input logic [3:0] bv);
    logic [7:0] r;
    logic [3:0] m;
    r = 8'h00;
    if (g < 3'd2 || g > 3'd4) return 8'h00;
    m = 4'((1 << g) - 1);
`ifdef CLMUL_OPERAND_MASK_EN
    av = av & m;
`endif
    bv = bv & m;
    for (int i = 0; i < 4; i++)
      if (bv[i]) r = r ^ (8'(av) << i);
    return r;
  endfunction

  // Launch one operation, measure latency / busy cycles, check result.
  // poke_at >= 0 pulses start with new operands during the run.
  task automatic do_op(input string name, input logic [2:0] g, input logic [3:0] av,
                       input logic [3:0] bv, input logic [7:0] exp, input int lat,
                       input int poke_at);
    int n;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; polyn_grade = g; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom); polyn_grade = 3'($urandom);
    chk({name, " prod held at start"}, 32'(prod), 32'(last_prod));
    n = 0; busy_cnt = 0;
    while (!op_finish && n < 20) begin
      busy_cnt += int'(busy);
      if (n == poke_at) begin
        start = 1'b1; a = 4'h3; b = 4'h5; polyn_grade = 3'd4;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " busy cycles"}, 32'(busy_cnt), 32'((lat == 1 && exp == 8'h00 && (g < 3'd2 || g > 3'd4)) ? 0 : lat));
    chk({name, " prod"}, 32'(prod), 32'(exp));
    last_prod = exp;
  endtask

  initial begin
    vec_t vecs[7];
    int   n;
    bit   fin_seen;
    logic [2:0] rg;
    logic [3:0] ra, rb;

    vecs[0] = '{3'd4, 4'hB, 4'h7, 8'h31, 4};
    vecs[1] = '{3'd4, 4'hF, 4'hF, 8'h55, 4};
`ifdef CLMUL_OPERAND_MASK_EN
    vecs[2] = '{3'd3, 4'hF, 4'hF, 8'h15, 3};
    vecs[3] = '{3'd2, 4'hF, 4'h2, 8'h06, 2};
`else
    vecs[2] = '{3'd3, 4'hF, 4'hF, 8'h2D, 3};
    vecs[3] = '{3'd2, 4'hF, 4'h2, 8'h1E, 2};
`endif
    vecs[4] = '{3'd1, 4'hF, 4'hF, 8'h00, 1};
    vecs[5] = '{3'd2, 4'h3, 4'h3, 8'h05, 2};
    vecs[6] = '{3'd5, 4'h9, 4'h9, 8'h00, 1};

    rst = 1'b1; start = 1'b0; polyn_grade = 3'd4; a = 4'h0; b = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset prod", 32'(prod), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset op_finish", 32'(op_finish), 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].g, vecs[i].av, vecs[i].bv, vecs[i].exp, vecs[i].lat, -1);

    // start pulsed during RUN must be ignored
    do_op("start in run", 3'd4, 4'hB, 4'h7, 8'h31, 4, 1);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; polyn_grade = 3'd4; a = 4'hF; b = 4'hF;
    @(posedge clk); #1;
    a = 4'h2; b = 4'h3;
    n = 0;
    while (!op_finish && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b first latency", 32'(n), 32'd4);
    chk("b2b first prod", 32'(prod), 32'h55);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!op_finish && n < 20);
    start = 1'b0;
    chk("b2b second spacing", 32'(n), 32'd5);
    chk("b2b second prod", 32'(prod), 32'h06);
    @(posedge clk); #1;
    chk("done one cycle", 32'(op_finish), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("prod holds idle", 32'(prod), 32'h06);
    last_prod = 8'h06;

    // Reset two cycles into a grade-4 operation
    @(negedge clk);
    start = 1'b1; polyn_grade = 3'd4; a = 4'hB; b = 4'h7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid-run reset prod", 32'(prod), 32'h0);
    chk("mid-run reset busy", 32'(busy), 32'h0);
    fin_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fin_seen = fin_seen | op_finish;
      @(posedge clk); #1;
    end
    chk("no finish after reset", 32'(fin_seen), 32'h0);
    last_prod = 8'h00;

    // Random operations, invalid grades included
    for (int i = 0; i < 40; i++) begin
      rg = 3'($urandom_range(0, 7));
      ra = 4'($urandom);
      rb = 4'($urandom);
      do_op($sformatf("rand%0d g%0d a%0h b%0h", i, rg, ra, rb), rg, ra, rb,
            ref_clmul(rg, ra, rb), (rg < 3'd2 || rg > 3'd4) ? 1 : int'(rg), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
